// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared memop codes, bus widths, zero constants and MEM-stage FSM states
package mem_stage_pkg;
  localparam int RegBus = 32;
  localparam int RegAddrBus = 5;
  localparam int MemOpBus = 4;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
  localparam logic [MemOpBus-1:0] MEM_NOP = 4'd0;
  localparam logic [MemOpBus-1:0] MEM_LB = 4'd1;
  localparam logic [MemOpBus-1:0] MEM_LBU = 4'd2;
  localparam logic [MemOpBus-1:0] MEM_LH = 4'd3;
  localparam logic [MemOpBus-1:0] MEM_LHU = 4'd4;
  localparam logic [MemOpBus-1:0] MEM_LW = 4'd5;
  localparam logic [MemOpBus-1:0] MEM_SB = 4'd6;
  localparam logic [MemOpBus-1:0] MEM_SH = 4'd7;
  localparam logic [MemOpBus-1:0] MEM_SW = 4'd8;
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE, S_ERR} mem_state_t;
endpackage

// File: rtl/mem_align.sv
// mem_align: combinational big-endian lane select (sel), store replication (wdata), load extension (ldata) and misalign/is_mem/is_store decode from memop, addr[1:0], sdata, rdata
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [MemOpBus-1:0] memop,
  input  logic [1:0]          addr,
  input  logic [RegBus-1:0]   sdata,
  input  logic [RegBus-1:0]   rdata,
  output logic [3:0]          sel,
  output logic [RegBus-1:0]   wdata,
  output logic [RegBus-1:0]   ldata,
  output logic                misalign,
  output logic                is_mem,
  output logic                is_store
);
  logic is_byte, is_half, is_word;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    is_byte = memop == MEM_LB || memop == MEM_LBU || memop == MEM_SB;
    is_half = memop == MEM_LH || memop == MEM_LHU || memop == MEM_SH;
    is_word = memop == MEM_LW || memop == MEM_SW;
    is_mem = is_byte | is_half | is_word;
    is_store = memop == MEM_SB || memop == MEM_SH || memop == MEM_SW;
    misalign = (is_half & addr[0]) | (is_word & |addr);
    b = 8'(rdata >> {~addr, 3'b000});
    h = 16'(rdata >> {~addr[1], 4'b0000});
    sel = is_byte ? 4'b1000 >> addr : is_half ? (addr[1] ? 4'b0011 : 4'b1100) : is_word ? 4'b1111 : 4'b0000;
    wdata = is_byte ? {4{sdata[7:0]}} : is_half ? {2{sdata[15:0]}} : sdata;
    ldata = memop == MEM_LB  ? {{24{b[7]}}, b} :
            memop == MEM_LBU ? {24'd0, b} :
            memop == MEM_LH  ? {{16{h[15]}}, h} :
            memop == MEM_LHU ? {16'd0, h} : rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage; EX/MEM inputs (wd_i/wreg_i/wdata_i/memop_i/maddr_i/sdata_i) to MEM/WB outputs (wd_o/wreg_o/wdata_o), stall_req/addr_err/bus_err status and a req/ack data bus (dbus_*)
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddrBus-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [RegBus-1:0]     wdata_i,
  input  logic [MemOpBus-1:0]   memop_i,
  input  logic [RegBus-1:0]     maddr_i,
  input  logic [RegBus-1:0]     sdata_i,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic                  stall_req,
  output logic                  addr_err,
  output logic                  bus_err,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [RegBus-1:0]     dbus_addr,
  output logic [3:0]            dbus_sel,
  output logic [RegBus-1:0]     dbus_wdata,
  input  logic                  dbus_ack,
  input  logic [RegBus-1:0]     dbus_rdata
);
  mem_state_t state, state_nxt;
  logic [TO_W-1:0] cnt, cnt_nxt;
  logic [RegBus-1:0] rdata_q, al_wdata, al_ldata;
  logic [3:0] al_sel;
  logic misalign, is_mem, is_store, timeout;
  mem_align u_align (
    .memop(memop_i), .addr(maddr_i[1:0]), .sdata(sdata_i), .rdata(rdata_q),
    .sel(al_sel), .wdata(al_wdata), .ldata(al_ldata),
    .misalign(misalign), .is_mem(is_mem), .is_store(is_store)
  );
  assign cnt_nxt = cnt + TO_W'(1);
  assign timeout = TIMEOUT != 0 && cnt_nxt == TO_W'(TIMEOUT);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      rdata_q <= ZeroWord;
    end else begin
      state <= state_nxt;
      cnt <= state == S_BUS ? cnt_nxt : '0;
      if (state == S_BUS && dbus_ack) rdata_q <= dbus_rdata;
    end
  end
  always_comb begin
    state_nxt = state;
    wd_o = NOPRegAddr;
    wreg_o = 1'b0;
    wdata_o = ZeroWord;
    stall_req = 1'b0;
    addr_err = 1'b0;
    bus_err = 1'b0;
    dbus_req = 1'b0;
    dbus_we = 1'b0;
    dbus_addr = ZeroWord;
    dbus_sel = 4'b0000;
    dbus_wdata = ZeroWord;
    if (!rst) begin
      wd_o = wd_i;
      wdata_o = wdata_i;
      case (state)
        S_IDLE: begin
          wreg_o = wreg_i & ~is_mem;
          addr_err = is_mem & misalign;
          stall_req = is_mem & ~misalign;
          state_nxt = stall_req ? S_BUS : S_IDLE;
        end
        S_BUS: begin
          stall_req = 1'b1;
          dbus_req = 1'b1;
          dbus_we = is_store;
          dbus_addr = {maddr_i[31:2], 2'b00};
          dbus_sel = al_sel;
          dbus_wdata = al_wdata;
          state_nxt = dbus_ack ? S_DONE : timeout ? S_ERR : S_BUS;
        end
        S_DONE: begin
          wreg_o = wreg_i & ~is_store;
          wdata_o = is_store ? wdata_i : al_ldata;
          state_nxt = S_IDLE;
        end
        S_ERR: begin
          bus_err = 1'b1;
          state_nxt = S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage against an arithmetic reference model
module tb_mem_stage;
  localparam int TIMEOUT = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] wd_i, wd_o;
  logic wreg_i, wreg_o, stall_req, addr_err, bus_err, dbus_req, dbus_we, dbus_ack;
  logic [31:0] wdata_i, maddr_i, sdata_i, wdata_o, dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0] memop_i, dbus_sel;
  logic [127:0] outs;
  always #5 clk = ~clk;
  mem_stage #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .memop_i(memop_i), .maddr_i(maddr_i), .sdata_i(sdata_i),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_req(stall_req),
    .addr_err(addr_err), .bus_err(bus_err), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
  );
  assign outs = {17'd0, wd_o, wreg_o, wdata_o, stall_req, addr_err, bus_err,
                 dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata};
  typedef struct {
    logic [4:0] wd;
    logic wreg;
    logic [31:0] wdata;
    logic aerr, berr, cmp, we;
    int stalls;
    logic [3:0] sel;
    logic [31:0] bdata, baddr;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int checks = 0, errors = 0, stall_cnt = 0;
  bit mon_en = 0;
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(logic [3:0] op, logic [4:0] wd, logic wreg, logic [31:0] wdata,
                                 logic [31:0] addr, logic [31:0] sdata, logic [31:0] rdata, int wn, bit ack);
    exp_t r;
    int size, k;
    logic [31:0] mask, v;
    size = (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 : (op == 5 || op == 8) ? 4 : 0;
    k = int'(addr[1:0]);
    r.wd = wd; r.wreg = wreg; r.wdata = wdata; r.aerr = 0; r.berr = 0; r.cmp = 1;
    r.we = 0; r.stalls = 0; r.sel = 0; r.bdata = 0; r.baddr = addr & ~32'd3;
    if (size == 0) return r;
    r.wreg = 0; r.cmp = 0;
    if (k % size != 0) begin r.aerr = 1; return r; end
    r.we = op >= 6;
    r.sel = 4'(((1 << size) - 1) << (4 - k - size));
    r.bdata = size == 1 ? (sdata & 32'hFF) * 32'h01010101 : size == 2 ? (sdata & 32'hFFFF) * 32'h00010001 : sdata;
    r.stalls = 1 + (ack ? wn : TIMEOUT);
    if (!ack) begin r.berr = 1; return r; end
    if (r.we) return r;
    mask = size == 4 ? 32'hFFFFFFFF : (32'd1 << (8 * size)) - 1;
    v = (rdata >> (8 * (4 - k - size))) & mask;
    if ((op == 1 || op == 3) && v[8 * size - 1]) v = v | ~mask;
    r.wreg = wreg; r.wdata = v; r.cmp = 1;
    return r;
  endfunction
  task automatic issue(logic [3:0] op, logic [4:0] wd, logic wreg, logic [31:0] wdata,
                       logic [31:0] addr, logic [31:0] sdata, logic [31:0] rdata, int wn, bit ack);
    int bc = 0, cyc = 0;
    bit done;
    memop_i = op; wd_i = wd; wreg_i = wreg; wdata_i = wdata; maddr_i = addr; sdata_i = sdata;
    exp_q.push_back(model(op, wd, wreg, wdata, addr, sdata, rdata, wn, ack));
    forever begin
      @(negedge clk);
      if (dbus_req) begin
        bc++;
        dbus_ack = ack && bc == wn;
        dbus_rdata = dbus_ack ? rdata : $urandom;
      end else begin
        dbus_ack = 1'($urandom_range(0, 1));
        dbus_rdata = $urandom;
      end
      done = !stall_req;
      @(posedge clk); #1;
      dbus_ack = 0;
      if (done) break;
      if (++cyc > 40) begin
        checks++; errors++;
        $display("FAIL retire_wait: no retire after %0d cycles", cyc);
        break;
      end
    end
  endtask
  always @(negedge clk) begin
    if (rst || !mon_en) stall_cnt = 0;
    else begin
      if (dbus_req) begin
        if (exp_q.size() == 0) chk("bus_no_exp", dbus_req, 0);
        else begin
          chk("dbus_we", dbus_we, exp_q[0].we);
          chk("dbus_sel", dbus_sel, exp_q[0].sel);
          chk("dbus_wdata", dbus_wdata, exp_q[0].bdata);
          chk("dbus_addr", dbus_addr, exp_q[0].baddr);
        end
      end
      if (stall_req) stall_cnt++;
      else if (exp_q.size() == 0) chk("retire_no_exp", stall_req, 1);
      else begin
        e = exp_q.pop_front();
        chk("dbus_req_retire", dbus_req, 0);
        chk("wreg_o", wreg_o, e.wreg);
        chk("addr_err", addr_err, e.aerr);
        chk("bus_err", bus_err, e.berr);
        chk("stall_cycles", stall_cnt, e.stalls);
        if (e.cmp) begin
          chk("wd_o", wd_o, e.wd);
          chk("wdata_o", wdata_o, e.wdata);
        end
        stall_cnt = 0;
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    memop_i = 0; wd_i = 5'd9; wreg_i = 1; wdata_i = 32'hCAFEF00D; maddr_i = 32'h123;
    sdata_i = 32'h55AA55AA; dbus_ack = 1; dbus_rdata = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs, 0);
    @(posedge clk); #1;
    rst = 0; dbus_ack = 0; mon_en = 1;
    issue(4'd0, 5'd3, 1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 1, 1);
    issue(4'd5, 5'd4, 1, 32'h0, 32'h100, 32'h0, 32'h12345678, 2, 1);
    issue(4'd5, 5'd4, 1, 32'h0, 32'h104, 32'h0, 32'h87654321, 1, 1);
    issue(4'd1, 5'd5, 1, 32'h0, 32'h103, 32'h0, 32'h000000F0, 1, 1);
    issue(4'd2, 5'd6, 1, 32'h0, 32'h103, 32'h0, 32'h000000F0, 3, 1);
    issue(4'd3, 5'd7, 1, 32'h0, 32'h102, 32'h0, 32'h1234F00D, 1, 1);
    issue(4'd7, 5'd8, 1, 32'h0, 32'h202, 32'hAAAA5678, 32'h0, 2, 1);
    issue(4'd6, 5'd8, 1, 32'h0, 32'h200, 32'h000000C3, 32'h0, 1, 1);
    issue(4'd5, 5'd9, 1, 32'h0, 32'h101, 32'h0, 32'h0, 1, 1);
    issue(4'd4, 5'd9, 1, 32'h0, 32'h103, 32'h0, 32'h0, 1, 1);
    issue(4'd5, 5'd10, 1, 32'h0, 32'h300, 32'h0, 32'h0, 1, 0);
    issue(4'd5, 5'd11, 1, 32'h0, 32'h300, 32'h0, 32'hA5A5A5A5, TIMEOUT, 1);
    issue(4'd12, 5'd12, 1, 32'h01020304, 32'h301, 32'h0, 32'h0, 1, 1);
    for (int i = 0; i < 60; i++)
      issue($urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8)),
            5'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
            $urandom_range(1, TIMEOUT), $urandom_range(0, 5) != 0);
    mon_en = 0;
    chk("queue_drained", exp_q.size(), 0);
    memop_i = 4'd5; maddr_i = 32'h100; wreg_i = 1; dbus_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_test_in_bus", dbus_req, 1);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_outputs", outs, 0);
    @(posedge clk); #1;
    rst = 0; memop_i = 0; wd_i = 5'd7; wreg_i = 1; wdata_i = 32'h13579BDF;
    @(negedge clk);
    chk("post_rst_req", dbus_req, 0);
    chk("post_rst_stall", stall_req, 0);
    chk("post_rst_pass", {wd_o, wreg_o, wdata_o}, {5'd7, 1'b1, 32'h13579BDF});
    @(posedge clk); #1;
    mon_en = 1;
    issue(4'd3, 5'd13, 1, 32'h0, 32'h400, 32'h0, 32'h80017FFF, TIMEOUT, 1);
    issue(4'd8, 5'd14, 1, 32'h0, 32'h404, 32'h11223344, 32'h0, 2, 1);
    mon_en = 0;
    chk("queue_drained_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
